uart_reg_bridge: RTL and testbench
==================================

// Module: uart_reg_bridge
// PURPOSE
// Command engine that sits on the user side of the buffered UART, and is the consumer of its RX FIFO and producer of its TX FIFO.
// Parses byte frames from the host into register-bus accesses on an internal 8-bit register bus, then queues one response byte per frame.
// Frames: 'W'(0x57) addr data -> write, reply 0x4B ('K'); 'R'(0x52) addr -> read, reply rdata; any other opcode -> reply 0x3F ('?').
// PARAMETERS
// TIMEOUT_CYCLES  1000000  max idle clk cycles between bytes of one frame before it is discarded (10 ms @ 100 MHz)
// PORTS
// clk          in   1  system clock, all logic on rising edge
// rst_n        in   1  asynchronous active-low reset
// rx_data      in   8  head byte of RX FIFO (first-word-fall-through, valid while rx_empty=0)
// rx_empty     in   1  RX FIFO empty
// rx_next      out  1  pop RX FIFO head this cycle
// tx_data      out  8  response byte to TX FIFO
// tx_en        out  1  push tx_data into TX FIFO this cycle
// tx_full      in   1  TX FIFO full
// reg_addr     out  8  register bus address
// reg_wdata    out  8  register bus write data
// reg_we       out  1  write strobe, one cycle
// reg_re       out  1  read strobe, one cycle
// reg_rdata    in   8  read data, valid exactly one cycle after reg_re
// busy         out  1  frame in progress (state != IDLE)
// err_timeout  out  1  one-cycle pulse: partial frame discarded by timeout
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, tx_data/reg_addr/reg_wdata/opcode/timer=0, all strobes and pulses 0. Partial frame lost.
// - States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND.
// - rx_next = (IDLE|GET_ADDR|GET_DATA) & ~rx_empty (never pops empty FIFO). tx_en = SEND & ~tx_full.
// - reg_we = (state==BUS_WR); reg_re = (state==BUS_RD). Strobes are decoded from state; tx_data/reg_addr/reg_wdata are registered.
// - IDLE: on ~rx_empty latch opcode; 0x57/0x52 -> GET_ADDR, else tx_data<=0x3F -> SEND.
// - GET_ADDR: on ~rx_empty latch reg_addr; opcode W -> GET_DATA, R -> BUS_RD.
// - GET_DATA: on ~rx_empty latch reg_wdata -> BUS_WR.
// - BUS_WR: one cycle; tx_data<=0x4B -> SEND. BUS_RD: one cycle -> WAIT_RD.
// - WAIT_RD: tx_data<=reg_rdata -> SEND.
// - SEND: hold until ~tx_full; push one byte -> IDLE. No timeout in SEND; backpressure stalls indefinitely.
// - Latency, all bytes already buffered: write pop@0,1,2; reg_we@3; tx_en@4. Read pop@0,1; reg_re@2; tx_en@4.
// - Back-to-back frames: next opcode is popped the cycle after tx_en (IDLE), with no extra bubble.
// - Timer: cleared on entry to GET_ADDR/GET_DATA and on every pop.
// - Timer: counts while in GET_ADDR/GET_DATA with rx_empty=1.
// - Timer expiry: at TIMEOUT_CYCLES-1 -> IDLE, err_timeout=1 for one cycle, no response byte.
// - Byte available on the expiry cycle: the byte is taken and no timeout occurs.
// - Timer width: $clog2(TIMEOUT_CYCLES)+1; the timer saturates and never wraps.
// - Opcode in IDLE is never timed out. Exactly one response byte per accepted opcode, except timed-out frames.
// TESTING
// - Preload 57 10 A5 -> reg_we @cycle3 with addr=0x10 wdata=0xA5; tx_en @cycle4 with tx_data=0x4B.
// - Preload 52 22, bus model returns 0x3C -> reg_re @cycle2 with addr=0x22; tx_data=0x3C pushed @cycle4.
// - Preload 41 -> no reg strobes; 0x3F pushed; busy low again the cycle after.
// - Push 57 only, TIMEOUT_CYCLES=16 -> err_timeout pulse 16 cycles later, no tx_en; a following 52 05 gets its read response.
// - Read frame with tx_full=1 for 50 cycles -> tx_en stays 0 and tx_data stays stable; single push when tx_full drops.
// - Assert rst_n=0 in GET_DATA -> all outputs 0 asynchronously; after release, a fresh 57 01 02 writes normally.

Source files
------------

// File: rtl/uart_reg_bridge_if.sv
// Bundle between the UART command engine and its neighbours: the RX FIFO
// (first-word-fall-through read side), the TX FIFO (push side), the 8-bit
// register bus and two status outputs.
//   master : the bridge (drives rx_next, tx_*, reg_addr/wdata/we/re, busy,
//            err_timeout; reads rx_data, rx_empty, tx_full, reg_rdata)
//   slave  : the FIFOs / register file / status consumer
interface uart_reg_bridge_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_next;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err_timeout;

  modport master (
    input  rx_data, rx_empty, tx_full, reg_rdata,
    output rx_next, tx_data, tx_en, reg_addr, reg_wdata, reg_we, reg_re,
           busy, err_timeout
  );

  modport slave (
    output rx_data, rx_empty, tx_full, reg_rdata,
    input  rx_next, tx_data, tx_en, reg_addr, reg_wdata, reg_we, reg_re,
           busy, err_timeout
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// Command engine on the user side of a buffered UART. Pops host bytes from
// the RX FIFO, parses 'W' addr data / 'R' addr frames into single-cycle
// register bus accesses and pushes exactly one response byte per accepted
// opcode ('K' for a write, read data for a read, '?' for an unknown opcode).
// A frame that stalls mid-way for TIMEOUT_CYCLES is dropped silently apart
// from a one-cycle err_timeout pulse.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_reg_bridge_if.master (RX/TX FIFO, register bus, status)
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  uart_reg_bridge_if.master bus
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_WAIT_RD,
    S_SEND
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pop;
  logic            waiting;
  logic            expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      tx_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      tx_data_q <= tx_data_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    tx_data_d = tx_data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    timer_d   = timer_q;
    pop       = 1'b0;
    expire    = 1'b0;
    waiting   = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);

    unique case (state_q)
      S_IDLE: begin
        if (!bus.rx_empty) begin
          pop      = 1'b1;
          opcode_d = bus.rx_data;
          if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
            state_d = S_GET_ADDR;
          end else begin
            tx_data_d = RSP_BAD;
            state_d   = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (!bus.rx_empty) begin
          pop     = 1'b1;
          addr_d  = bus.rx_data;
          state_d = (opcode_q == OP_WRITE) ? S_GET_DATA : S_BUS_RD;
        end else if (timer_q == TIMER_LAST) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (!bus.rx_empty) begin
          pop     = 1'b1;
          wdata_d = bus.rx_data;
          state_d = S_BUS_WR;
        end else if (timer_q == TIMER_LAST) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BUS_WR: begin
        tx_data_d = RSP_OK;
        state_d   = S_SEND;
      end
      S_BUS_RD: begin
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        tx_data_d = bus.reg_rdata;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!bus.tx_full) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every entry to GET_ADDR/GET_DATA coincides with a pop, so clearing on
    // pop also covers clearing on entry. The counter saturates instead of
    // wrapping so a huge TIMEOUT_CYCLES can never alias back to zero.
    if (pop) begin
      timer_d = '0;
    end else if (waiting && bus.rx_empty && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign bus.rx_next     = pop;
  assign bus.tx_en       = (state_q == S_SEND) && !bus.tx_full;
  assign bus.tx_data     = tx_data_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = (state_q == S_BUS_WR);
  assign bus.reg_re      = (state_q == S_BUS_RD);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.err_timeout = expire;

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_reg_bridge_if bus ();

  uart_reg_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // RX FIFO model and byte schedule (byte i enters the FIFO at cycle seq_at[i])
  logic [7:0] fifo[$];
  logic [7:0] seq_b[8];
  int         seq_at[8];
  int         seq_n;

  task automatic add(input logic [7:0] b, input int at);
    seq_b[seq_n]  = b;
    seq_at[seq_n] = at;
    seq_n++;
  endtask

  task automatic refresh_rx();
    bus.rx_empty = (fifo.size() == 0);
    bus.rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // Observations of one run, cycle numbers relative to the run start
  int         we_c, re_c, tx_c, tx_c2, tx_n, we_n, re_n, to_c, to_n, stall_chg;
  logic [7:0] we_addr, we_data, re_addr, tx_d, tx_d2, prev_txd;
  logic       busy_log[64];
  logic       busy_last;

  // Register file model: read data is addr ^ 0x1E, valid only the cycle
  // after reg_re; every other cycle shows 0xEE.
  task automatic run(input int budget, input int full_until);
    logic       pop_s, re_s;
    logic [7:0] addr_s, tmp;
    we_c = -1; re_c = -1; tx_c = -1; tx_c2 = -1; to_c = -1;
    tx_n = 0; we_n = 0; re_n = 0; to_n = 0; stall_chg = 0;
    we_addr = '0; we_data = '0; re_addr = '0; tx_d = '0; tx_d2 = '0;
    prev_txd = bus.tx_data;
    for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      for (int i = 0; i < seq_n; i++) if (seq_at[i] == c) fifo.push_back(seq_b[i]);
      bus.tx_full = (c < full_until);
      refresh_rx();
      #1;
      if (c < 64) busy_log[c] = bus.busy;
      busy_last = bus.busy;
      if (bus.reg_we) begin
        we_n++;
        if (we_c < 0) begin we_c = c; we_addr = bus.reg_addr; we_data = bus.reg_wdata; end
      end
      if (bus.reg_re) begin
        re_n++;
        if (re_c < 0) begin re_c = c; re_addr = bus.reg_addr; end
      end
      if (bus.tx_en) begin
        tx_n++;
        if (tx_c < 0) begin tx_c = c; tx_d = bus.tx_data; end
        else begin tx_c2 = c; tx_d2 = bus.tx_data; end
      end
      if (bus.err_timeout) begin
        to_n++;
        if (to_c < 0) to_c = c;
      end
      if (bus.tx_full && bus.busy && c >= 5 && bus.tx_data != prev_txd) stall_chg++;
      prev_txd = bus.tx_data;
      pop_s  = bus.rx_next;
      re_s   = bus.reg_re;
      addr_s = bus.reg_addr;
      @(posedge clk);
      #1;
      if (pop_s && fifo.size() != 0) tmp = fifo.pop_front();
      bus.reg_rdata = re_s ? (addr_s ^ 8'h1E) : 8'hEE;
      refresh_rx();
    end
    bus.tx_full = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    int         we_c;
    int         re_c;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         tx_c;
    logic [7:0] tx_d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bus.rx_empty  = 1'b1;
    bus.rx_data   = 8'h00;
    bus.tx_full   = 1'b0;
    bus.reg_rdata = 8'hEE;

    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3,  3, -1, 8'h10, 8'hA5, 4, 8'h4B};
    vecs[1] = '{8'h52, 8'h22, 8'h00, 2, -1,  2, 8'h22, 8'h00, 4, 8'h3C};
    vecs[2] = '{8'h41, 8'h00, 8'h00, 1, -1, -1, 8'h00, 8'h00, 1, 8'h3F};
    vecs[3] = '{8'h57, 8'hFF, 8'h00, 3,  3, -1, 8'hFF, 8'h00, 4, 8'h4B};
    vecs[4] = '{8'h52, 8'h05, 8'h00, 2, -1,  2, 8'h05, 8'h00, 4, 8'h1B};
    vecs[5] = '{8'h52, 8'hFF, 8'h00, 2, -1,  2, 8'hFF, 8'h00, 4, 8'hE1};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1, -1, -1, 8'h00, 8'h00, 1, 8'h3F};
    vecs[7] = '{8'h77, 8'h00, 8'h00, 1, -1, -1, 8'h00, 8'h00, 1, 8'h3F};

    // Reset state
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_reg_addr", int'(bus.reg_addr), 0);
    chk("rst_strobes", int'({bus.reg_we, bus.reg_re, bus.tx_en, bus.err_timeout, bus.rx_next}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single frames, all bytes buffered at cycle 0
    for (int v = 0; v < 8; v++) begin
      seq_n = 0;
      add(vecs[v].b0, 0);
      if (vecs[v].nb > 1) add(vecs[v].b1, 0);
      if (vecs[v].nb > 2) add(vecs[v].b2, 0);
      run(8, 0);
      chk($sformatf("v%0d_we_cycle", v), we_c, vecs[v].we_c);
      chk($sformatf("v%0d_re_cycle", v), re_c, vecs[v].re_c);
      if (vecs[v].we_c >= 0) begin
        chk($sformatf("v%0d_we_addr", v), int'(we_addr), int'(vecs[v].addr));
        chk($sformatf("v%0d_we_data", v), int'(we_data), int'(vecs[v].wdata));
      end
      if (vecs[v].re_c >= 0) chk($sformatf("v%0d_re_addr", v), int'(re_addr), int'(vecs[v].addr));
      chk($sformatf("v%0d_tx_cycle", v), tx_c, vecs[v].tx_c);
      chk($sformatf("v%0d_tx_data", v), int'(tx_d), int'(vecs[v].tx_d));
      chk($sformatf("v%0d_tx_count", v), tx_n, 1);
      chk($sformatf("v%0d_timeouts", v), to_n, 0);
      chk($sformatf("v%0d_busy_after_tx", v), int'(busy_log[vecs[v].tx_c + 1]), 0);
    end

    // Back-to-back: write then read with no bubble between frames
    seq_n = 0;
    add(8'h57, 0); add(8'h01, 0); add(8'h02, 0); add(8'h52, 0); add(8'h01, 0);
    run(12, 0);
    chk("b2b_tx_count", tx_n, 2);
    chk("b2b_tx1_cycle", tx_c, 4);
    chk("b2b_tx1_data", int'(tx_d), 8'h4B);
    chk("b2b_re_cycle", re_c, 7);
    chk("b2b_tx2_cycle", tx_c2, 9);
    chk("b2b_tx2_data", int'(tx_d2), 8'h1F);

    // Lone opcode: frame discarded after 16 idle cycles
    seq_n = 0;
    add(8'h57, 0);
    run(20, 0);
    chk("to_cycle", to_c, 16);
    chk("to_pulses", to_n, 1);
    chk("to_tx_count", tx_n, 0);
    chk("to_we_count", we_n, 0);
    chk("to_busy_16", int'(busy_log[16]), 1);
    chk("to_busy_17", int'(busy_log[17]), 0);
    seq_n = 0;
    add(8'h52, 0); add(8'h05, 0);
    run(8, 0);
    chk("after_to_tx_cycle", tx_c, 4);
    chk("after_to_tx_data", int'(tx_d), 8'h1B);

    // Byte arriving exactly on the expiry cycle is accepted
    seq_n = 0;
    add(8'h57, 0); add(8'h30, 16); add(8'h31, 20);
    run(26, 0);
    chk("edge_timeouts", to_n, 0);
    chk("edge_we_cycle", we_c, 21);
    chk("edge_we_addr", int'(we_addr), 8'h30);
    chk("edge_we_data", int'(we_data), 8'h31);
    chk("edge_tx_cycle", tx_c, 22);
    chk("edge_tx_data", int'(tx_d), 8'h4B);

    // TX backpressure for 50 cycles after the response is ready
    seq_n = 0;
    add(8'h52, 0); add(8'h22, 0);
    run(60, 54);
    chk("bp_tx_count", tx_n, 1);
    chk("bp_tx_cycle", tx_c, 54);
    chk("bp_tx_data", int'(tx_d), 8'h3C);
    chk("bp_data_changes", stall_chg, 0);
    chk("bp_busy_mid", int'(busy_log[30]), 1);
    chk("bp_timeouts", to_n, 0);

    // Asynchronous reset while waiting for the data byte
    seq_n = 0;
    add(8'h57, 0); add(8'h01, 1);
    run(5, 0);
    chk("mid_busy_before_rst", int'(bus.busy), 1);
    chk("mid_addr_before_rst", int'(bus.reg_addr), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_addr", int'(bus.reg_addr), 0);
    chk("arst_wdata", int'(bus.reg_wdata), 0);
    chk("arst_tx_data", int'(bus.tx_data), 0);
    chk("arst_strobes", int'({bus.reg_we, bus.reg_re, bus.tx_en, bus.err_timeout, bus.rx_next}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seq_n = 0;
    add(8'h57, 0); add(8'h01, 0); add(8'h02, 0);
    run(8, 0);
    chk("post_rst_we_cycle", we_c, 3);
    chk("post_rst_we_addr", int'(we_addr), 8'h01);
    chk("post_rst_we_data", int'(we_data), 8'h02);
    chk("post_rst_tx_cycle", tx_c, 4);
    chk("post_rst_tx_data", int'(tx_d), 8'h4B);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
